// File: rtl/frame_overlap_buffer.sv
// ============================================================================
// frame_overlap_buffer : slices a sample stream into N-sample frames that start
// HOP samples apart, using a 2N-deep circular RAM.  Revision 1.0
// ============================================================================
`default_nettype none

module frame_overlap_buffer #(
  parameter int N      = 1024,
  parameter int HOP    = 512,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [DATA_W-1:0] m_data,
  output logic [15:0]       frame_cnt
);

  localparam int C_DEPTH = 2 * N;
  localparam int C_AW    = $clog2(C_DEPTH);
  localparam int C_PW    = C_AW + 1;
  localparam logic [C_PW-1:0] C_N        = C_PW'(N);
  localparam logic [C_PW-1:0] C_HOP      = C_PW'(HOP);
  localparam logic [C_PW-1:0] C_DEPTH_P  = C_PW'(C_DEPTH);
  localparam logic [C_PW-1:0] C_LAST_IDX = C_PW'(N - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_t;

  state_t            r_state;
  logic [C_PW-1:0]   r_wr_ptr;
  logic [C_PW-1:0]   r_fs_ptr;
  logic [C_PW-1:0]   r_rd_base;
  logic [C_PW-1:0]   r_rd_idx;
  logic              r_pend;
  logic [DATA_W-1:0] r_mem [C_DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_vld;
  logic              r_rd_last;
  logic [2:0]        r_q_vld;
  logic [2:0]        r_q_last;
  logic [DATA_W-1:0] r_q_data [3];

  logic              w_wr;
  logic              w_deq;
  logic              w_frame_done;
  logic              w_idle;
  logic              w_apply;
  logic              w_issue;
  logic              w_issue_last;
  logic [C_PW-1:0]   w_avail;
  logic [2:0]        w_inflight;
  logic [C_AW-1:0]   w_rd_addr;
  logic [C_PW-1:0]   w_wr_next;
  logic [C_PW-1:0]   w_fs_next;
  logic [C_PW-1:0]   w_fill_next;
  logic [2:0]        w_q_vld;
  logic [2:0]        w_q_last;
  logic [DATA_W-1:0] w_q_data [3];
  logic              w_slot_found;

  assign m_valid = r_q_vld[0];
  assign m_last  = r_q_last[0];
  assign m_data  = r_q_data[0];

  assign w_wr         = s_valid & s_ready;
  assign w_deq        = r_q_vld[0] & m_ready;
  assign w_frame_done = w_deq & r_q_last[0];
  assign w_avail      = r_wr_ptr - r_rd_base;
  assign w_inflight   = 3'(r_q_vld[0]) + 3'(r_q_vld[1]) + 3'(r_q_vld[2])
                      + 3'(r_rd_vld) - 3'(w_deq);
  assign w_idle       = (r_state == ST_IDLE) & ~r_rd_vld & (r_q_vld == 3'b000);
  assign w_apply      = r_pend & (w_frame_done | w_idle);
  // Reads may run ahead of the output into the next frame, bounded by the
  // three output slots, so the issue base never leads fs_ptr by more than HOP.
  assign w_issue      = ~w_apply & (w_inflight < 3'd3) &
                        ((r_state == ST_PLAY) | ((w_avail >= C_N) & ~r_pend & ~flush));
  assign w_issue_last = (r_rd_idx == C_LAST_IDX);
  assign w_rd_addr    = r_rd_base[C_AW-1:0] + r_rd_idx[C_AW-1:0];

  assign w_wr_next    = r_wr_ptr + C_PW'(w_wr);
  assign w_fs_next    = w_apply ? r_wr_ptr : (w_frame_done ? r_fs_ptr + C_HOP : r_fs_ptr);
  assign w_fill_next  = w_wr_next - w_fs_next;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[C_AW-1:0]] <= s_data;
    if (w_issue) r_rd_data <= r_mem[w_rd_addr];
  end

  // Output queue: entry 0 is the visible beat, entries 1..2 absorb the skid.
  always_comb begin
    w_q_vld      = r_q_vld;
    w_q_last     = r_q_last;
    w_q_data     = r_q_data;
    w_slot_found = 1'b0;
    if (w_deq) begin
      w_q_vld     = {1'b0, r_q_vld[2:1]};
      w_q_last    = {1'b0, r_q_last[2:1]};
      w_q_data[0] = r_q_data[1];
      w_q_data[1] = r_q_data[2];
    end
    if (r_rd_vld) begin
      for (int i = 0; i < 3; i++) begin
        if (!w_q_vld[i] && !w_slot_found) begin
          w_q_vld[i]   = 1'b1;
          w_q_last[i]  = r_rd_last;
          w_q_data[i]  = r_rd_data;
          w_slot_found = 1'b1;
        end
      end
    end
    if (w_apply) begin
      w_q_vld  = 3'b000;
      w_q_last = 3'b000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_fs_ptr  <= '0;
      r_rd_base <= '0;
      r_rd_idx  <= '0;
      r_pend    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
      r_q_vld   <= 3'b000;
      r_q_last  <= 3'b000;
      for (int i = 0; i < 3; i++) r_q_data[i] <= '0;
      frame_cnt <= 16'd0;
      s_ready   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_fs_ptr <= w_fs_next;
      s_ready  <= (w_fill_next < C_DEPTH_P);
      r_pend   <= w_apply ? 1'b0 : (r_pend | flush);
      if (w_frame_done) frame_cnt <= frame_cnt + 16'd1;
      r_rd_vld <= w_issue;
      if (w_issue) r_rd_last <= w_issue_last;
      r_q_vld  <= w_q_vld;
      r_q_last <= w_q_last;
      r_q_data <= w_q_data;
      if (w_apply) begin
        r_state   <= ST_IDLE;
        r_rd_idx  <= '0;
        r_rd_base <= r_wr_ptr;
      end else if (w_issue) begin
        if (w_issue_last) begin
          r_state   <= ST_IDLE;
          r_rd_idx  <= '0;
          r_rd_base <= r_rd_base + C_HOP;
        end else begin
          r_state  <= ST_PLAY;
          r_rd_idx <= r_rd_idx + C_PW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_overlap_buffer.sv
// ============================================================================
// tb_frame_overlap_buffer : self-checking bench for frame_overlap_buffer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_frame_overlap_buffer;

  localparam int N     = 8;
  localparam int HOP_A = 4;
  localparam int HOP_B = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_s_valid = 1'b0, a_s_ready, a_flush = 1'b0;
  logic        a_m_valid, a_m_ready = 1'b0, a_m_last;
  logic [15:0] a_s_data = '0, a_m_data, a_frame_cnt;

  logic        b_s_valid = 1'b0, b_s_ready, b_flush = 1'b0;
  logic        b_m_valid, b_m_ready = 1'b0, b_m_last;
  logic [15:0] b_s_data = '0, b_m_data, b_frame_cnt;

  always #5 clk = ~clk;

  frame_overlap_buffer #(.N(N), .HOP(HOP_A), .DATA_W(16)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .flush(a_flush), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_last(a_m_last),
    .m_data(a_m_data), .frame_cnt(a_frame_cnt)
  );

  frame_overlap_buffer #(.N(N), .HOP(HOP_B), .DATA_W(16)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .flush(b_flush), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last),
    .m_data(b_m_data), .frame_cnt(b_frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: every accepted input in order, and every output beat seen.
  logic [15:0] nxt;
  logic [15:0] sq[$];
  logic [15:0] oq_d[$];
  logic        oq_l[$];

  function automatic int n_lasts();
    int k = 0;
    foreach (oq_l[i]) if (oq_l[i]) k++;
    return k;
  endfunction

  task automatic cycle_a(input logic sv, input logic mr, input logic fl);
    a_s_valid = sv;
    a_s_data  = nxt;
    a_m_ready = mr;
    a_flush   = fl;
    if (a_s_valid && a_s_ready) begin
      sq.push_back(nxt);
      nxt = nxt + 16'd1;
    end
    if (a_m_valid && a_m_ready) begin
      oq_d.push_back(a_m_data);
      oq_l.push_back(a_m_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_s_valid = 0; a_m_ready = 0; a_flush = 0;
    b_s_valid = 0; b_m_ready = 0; b_flush = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sq.delete(); oq_d.delete(); oq_l.delete();
    nxt = 16'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    n_cmp += 10;
    if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_m_valid got %b want 0", a_m_valid); end
    if (a_m_last !== 1'b0) begin n_err++; $display("FAIL reset_a_m_last got %b want 0", a_m_last); end
    if (a_m_data !== 16'h0) begin n_err++; $display("FAIL reset_a_m_data got %h want 0", a_m_data); end
    if (a_frame_cnt !== 16'h0) begin n_err++; $display("FAIL reset_a_frame_cnt got %0d want 0", a_frame_cnt); end
    if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_s_ready got %b want 0", a_s_ready); end
    if (b_m_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_m_valid got %b want 0", b_m_valid); end
    if (b_m_last !== 1'b0) begin n_err++; $display("FAIL reset_b_m_last got %b want 0", b_m_last); end
    if (b_m_data !== 16'h0) begin n_err++; $display("FAIL reset_b_m_data got %h want 0", b_m_data); end
    if (b_frame_cnt !== 16'h0) begin n_err++; $display("FAIL reset_b_frame_cnt got %0d want 0", b_frame_cnt); end
    if (b_s_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_s_ready got %b want 0", b_s_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp += 2;
    if (a_s_ready !== 1'b1) begin n_err++; $display("FAIL release_a_s_ready got %b want 1", a_s_ready); end
    if (b_s_ready !== 1'b1) begin n_err++; $display("FAIL release_b_s_ready got %b want 1", b_s_ready); end
  endtask

  task automatic test_overlap();
    do_reset();
    for (int c = 0; c < 200 && n_lasts() < 3; c++) cycle_a(1'b1, 1'b1, 1'b0);
    n_cmp += 2;
    if (n_lasts() != 3) begin n_err++; $display("FAIL overlap_frames got %0d want 3", n_lasts()); end
    if (a_frame_cnt !== 16'd3) begin n_err++; $display("FAIL overlap_frame_cnt got %0d want 3", a_frame_cnt); end
    for (int j = 0; j < 3 * N && j < oq_d.size(); j++) begin
      int idx = (j / N) * HOP_A + (j % N);
      n_cmp += 2;
      if (idx >= sq.size() || oq_d[j] !== sq[idx]) begin
        n_err++; $display("FAIL overlap_data beat %0d got %h want sample %0d", j, oq_d[j], idx);
      end
      if (oq_l[j] !== ((j % N) == N - 1)) begin
        n_err++; $display("FAIL overlap_last beat %0d got %b want %b", j, oq_l[j], (j % N) == N - 1);
      end
    end
  endtask

  task automatic test_no_overlap();
    logic [15:0] bq_in[$];
    logic [15:0] bq_d[$];
    logic        bq_l[$];
    logic [15:0] bnxt = 16'd0;
    int w7 = -1, first = -1, lasts = 0;
    do_reset();
    for (int c = 0; c < 100 && lasts < 2; c++) begin
      b_s_valid = 1'b1;
      b_s_data  = bnxt;
      b_m_ready = 1'b1;
      if (b_s_valid && b_s_ready) begin
        bq_in.push_back(bnxt);
        if (bnxt == 16'd7) w7 = c;
        bnxt = bnxt + 16'd1;
      end
      if (b_m_valid) begin
        if (first < 0) first = c;
        bq_d.push_back(b_m_data);
        bq_l.push_back(b_m_last);
        if (b_m_last) lasts++;
      end
      @(posedge clk);
      #1;
    end
    b_s_valid = 1'b0;
    n_cmp += 3;
    if (lasts != 2) begin n_err++; $display("FAIL nooverlap_frames got %0d want 2", lasts); end
    if (first - w7 != 3) begin n_err++; $display("FAIL nooverlap_latency got %0d want 3", first - w7); end
    if (b_frame_cnt !== 16'd2) begin n_err++; $display("FAIL nooverlap_frame_cnt got %0d want 2", b_frame_cnt); end
    for (int j = 0; j < 2 * N && j < bq_d.size(); j++) begin
      int idx = (j / N) * HOP_B + (j % N);
      n_cmp += 2;
      if (idx >= bq_in.size() || bq_d[j] !== bq_in[idx]) begin
        n_err++; $display("FAIL nooverlap_data beat %0d got %h want sample %0d", j, bq_d[j], idx);
      end
      if (bq_l[j] !== ((j % N) == N - 1)) begin
        n_err++; $display("FAIL nooverlap_last beat %0d got %b", j, bq_l[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic        seen = 1'b0;
    logic [15:0] held_d = '0;
    logic        held_l = 1'b0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (seen) begin
        n_cmp++;
        if (a_m_valid !== 1'b1 || a_m_data !== held_d || a_m_last !== held_l) begin
          n_err++; $display("FAIL stall_hold cycle %0d got v=%b d=%h want v=1 d=%h", c, a_m_valid, a_m_data, held_d);
        end
      end else if (a_m_valid) begin
        seen = 1'b1; held_d = a_m_data; held_l = a_m_last;
      end
      cycle_a(1'b1, 1'b0, 1'b0);
    end
    n_cmp += 3;
    if (sq.size() != 16) begin n_err++; $display("FAIL stall_accepted got %0d want 16", sq.size()); end
    if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL stall_s_ready got %b want 0", a_s_ready); end
    if (seen !== 1'b1) begin n_err++; $display("FAIL stall_m_valid got %b want 1", seen); end
    for (int c = 0; c < 200 && n_lasts() < 3; c++) cycle_a(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (n_lasts() != 3) begin n_err++; $display("FAIL stall_frames got %0d want 3", n_lasts()); end
    for (int j = 0; j < 3 * N && j < oq_d.size(); j++) begin
      int idx = (j / N) * HOP_A + (j % N);
      n_cmp += 2;
      if (idx >= sq.size() || oq_d[j] !== sq[idx]) begin
        n_err++; $display("FAIL stall_data beat %0d got %h want sample %0d", j, oq_d[j], idx);
      end
      if (oq_l[j] !== ((j % N) == N - 1)) begin
        n_err++; $display("FAIL stall_last beat %0d got %b", j, oq_l[j]);
      end
    end
  endtask

  task automatic test_random_stall();
    do_reset();
    for (int c = 0; c < 2000; c++)
      cycle_a($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0);
    a_s_valid = 1'b0;
    n_cmp += 2;
    if (oq_d.size() < 400) begin n_err++; $display("FAIL random_beats got %0d want >=400", oq_d.size()); end
    if (a_frame_cnt !== 16'(n_lasts())) begin
      n_err++; $display("FAIL random_frame_cnt got %0d want %0d", a_frame_cnt, n_lasts());
    end
    for (int j = 0; j < oq_d.size(); j++) begin
      int idx = (j / N) * HOP_A + (j % N);
      n_cmp += 2;
      if (idx >= sq.size() || oq_d[j] !== sq[idx]) begin
        n_err++; $display("FAIL random_data beat %0d got %h want sample %0d", j, oq_d[j], idx);
      end
      if (oq_l[j] !== ((j % N) == N - 1)) begin
        n_err++; $display("FAIL random_last beat %0d got %b", j, oq_l[j]);
      end
    end
  endtask

  task automatic test_flush();
    logic flushed = 1'b0;
    logic fl;
    int   base;
    do_reset();
    for (int c = 0; c < 200 && n_lasts() < 1; c++) begin
      fl = a_m_valid && !flushed;
      if (fl) flushed = 1'b1;
      cycle_a(sq.size() < 12, 1'b1, fl);
    end
    repeat (10) cycle_a(1'b0, 1'b1, 1'b0);
    base = sq.size();
    n_cmp += 3;
    if (oq_d.size() != N) begin n_err++; $display("FAIL flush_first_beats got %0d want %0d", oq_d.size(), N); end
    if (a_frame_cnt !== 16'd1) begin n_err++; $display("FAIL flush_frame_cnt1 got %0d want 1", a_frame_cnt); end
    if (base != 12) begin n_err++; $display("FAIL flush_accepted got %0d want 12", base); end
    for (int c = 0; c < 200 && n_lasts() < 2; c++) cycle_a(sq.size() < base + N, 1'b1, 1'b0);
    n_cmp += 2;
    if (oq_d.size() != 2 * N) begin n_err++; $display("FAIL flush_beats got %0d want %0d", oq_d.size(), 2 * N); end
    if (a_frame_cnt !== 16'd2) begin n_err++; $display("FAIL flush_frame_cnt2 got %0d want 2", a_frame_cnt); end
    for (int j = 0; j < 2 * N && j < oq_d.size(); j++) begin
      int idx = (j < N) ? j : base + (j - N);
      n_cmp += 2;
      if (idx >= sq.size() || oq_d[j] !== sq[idx]) begin
        n_err++; $display("FAIL flush_data beat %0d got %h want sample %0d", j, oq_d[j], idx);
      end
      if (oq_l[j] !== ((j % N) == N - 1)) begin
        n_err++; $display("FAIL flush_last beat %0d got %b", j, oq_l[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 200 && !(oq_d.size() == N + 3 && a_m_valid); c++) cycle_a(1'b1, 1'b1, 1'b0);
    n_cmp += 2;
    if (!(oq_d.size() == N + 3 && a_m_valid)) begin n_err++; $display("FAIL midrst_reach got %0d beats", oq_d.size()); end
    if (a_frame_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_pre_cnt got %0d want 1", a_frame_cnt); end
    rst = 1'b1;
    #1;
    n_cmp += 5;
    if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL midrst_m_valid got %b want 0", a_m_valid); end
    if (a_m_last !== 1'b0) begin n_err++; $display("FAIL midrst_m_last got %b want 0", a_m_last); end
    if (a_m_data !== 16'h0) begin n_err++; $display("FAIL midrst_m_data got %h want 0", a_m_data); end
    if (a_frame_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_frame_cnt got %0d want 0", a_frame_cnt); end
    if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL midrst_s_ready got %b want 0", a_s_ready); end
    a_s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sq.delete(); oq_d.delete(); oq_l.delete();
    nxt = 16'd0;
    n_cmp++;
    if (a_frame_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_post_cnt got %0d want 0", a_frame_cnt); end
    for (int c = 0; c < 200 && n_lasts() < 1; c++) cycle_a(1'b1, 1'b1, 1'b0);
    n_cmp += 2;
    if (n_lasts() != 1) begin n_err++; $display("FAIL midrst_frames got %0d want 1", n_lasts()); end
    if (a_frame_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_end_cnt got %0d want 1", a_frame_cnt); end
    for (int j = 0; j < N && j < oq_d.size(); j++) begin
      n_cmp += 2;
      if (j >= sq.size() || oq_d[j] !== sq[j] || oq_d[j] !== 16'(j)) begin
        n_err++; $display("FAIL midrst_data beat %0d got %h want %h", j, oq_d[j], 16'(j));
      end
      if (oq_l[j] !== (j == N - 1)) begin
        n_err++; $display("FAIL midrst_last beat %0d got %b", j, oq_l[j]);
      end
    end
  endtask

  initial begin
    nxt = 16'd0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_backpressure();
    test_random_stall();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
